// File: rtl/regwrite_trace_fifo_if.sv
// Trace port bundle: core writeback bus in, show-ahead trace stream out.
// The master side is the core/sink environment; the slave side is the trace FIFO.
interface regwrite_trace_fifo_if #(
    parameter int unsigned TS_W = 16
);
    logic            RegWrite;
    logic [4:0]      WriteRegister;
    logic [31:0]     WriteDataReg;
    logic [31:0]     PC;
    logic            trace_ready;
    logic            trace_valid;
    logic [31:0]     trace_pc;
    logic [4:0]      trace_reg;
    logic [31:0]     trace_data;
    logic [TS_W-1:0] trace_ts;

    modport master (
        output RegWrite, WriteRegister, WriteDataReg, PC, trace_ready,
        input  trace_valid, trace_pc, trace_reg, trace_data, trace_ts
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteDataReg, PC, trace_ready,
        output trace_valid, trace_pc, trace_reg, trace_data, trace_ts
    );
endinterface

// File: rtl/regwrite_trace_fifo.sv
// Register-writeback trace FIFO: records qualifying core writebacks with a
// cycle timestamp, never stalls the core, drops and counts on overflow.
module regwrite_trace_fifo #(
    parameter int unsigned DEPTH     = 8,
    parameter bit          SKIP_ZERO = 1'b1,
    parameter int unsigned TS_W      = 16
) (
    input  logic                    Clk,
    input  logic                    reset,
    input  logic                    trace_en,
    input  logic                    ovf_clr,
    regwrite_trace_fifo_if.slave    bus,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow,
    output logic [7:0]              drop_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = 32 + 5 + 32 + TS_W;

    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [TS_W-1:0] ts;
    logic [EW-1:0]   head;
    logic            cap;
    logic            valid;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;

    always_comb begin
        cap   = trace_en & bus.RegWrite & ~(SKIP_ZERO & (bus.WriteRegister == 5'd0));
        valid = (count != '0);
        full  = (count == (AW+1)'(DEPTH));
        pop   = valid & bus.trace_ready;
        // a pop in the same edge frees the slot, so a full FIFO still accepts
        push  = cap & (~full | pop);
        drop  = cap & full & ~pop;
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ts     <= '0;
        end else begin
            ts <= ts + TS_W'(1);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow   <= 1'b1;
            drop_count <= ovf_clr ? 8'd1 : ((drop_count == '1) ? '1 : drop_count + 8'd1);
        end else if (ovf_clr) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr] <= {bus.PC, bus.WriteRegister, bus.WriteDataReg, ts};
    end

    // head slot is masked so the outputs read zero whenever nothing is held
    always_comb begin
        head            = mem[rd_ptr];
        bus.trace_valid = valid;
        bus.trace_pc    = valid ? head[EW-1 -: 32]        : '0;
        bus.trace_reg   = valid ? head[TS_W+36 -: 5]      : '0;
        bus.trace_data  = valid ? head[TS_W+31 -: 32]     : '0;
        bus.trace_ts    = valid ? head[TS_W-1:0]          : '0;
    end

    assign fifo_count = count;
endmodule

// File: tb/tb_regwrite_trace_fifo.sv
// Scoreboard bench for regwrite_trace_fifo: queue-based reference model and
// an independent negedge monitor, directed scenarios plus random traffic.
module tb_regwrite_trace_fifo;
    localparam int unsigned DEPTH     = 8;
    localparam bit          SKIP_ZERO = 1'b1;
    localparam int unsigned TS_W      = 16;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  r;
        logic [31:0] d;
        logic [15:0] ts;
    } entry_t;

    logic       Clk = 1'b0;
    logic       reset = 1'b0;
    logic       trace_en = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [3:0] fifo_count;
    logic       overflow;
    logic [7:0] drop_count;

    regwrite_trace_fifo_if #(.TS_W(TS_W)) bus ();

    regwrite_trace_fifo #(
        .DEPTH(DEPTH),
        .SKIP_ZERO(SKIP_ZERO),
        .TS_W(TS_W)
    ) dut (
        .Clk(Clk),
        .reset(reset),
        .trace_en(trace_en),
        .ovf_clr(ovf_clr),
        .bus(bus),
        .fifo_count(fifo_count),
        .overflow(overflow),
        .drop_count(drop_count)
    );

    always #5 Clk = ~Clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    entry_t      exp_q[$];
    int          m_cnt  = 0;
    logic [15:0] m_ts   = '0;
    bit          m_ovf  = 1'b0;
    int          m_drop = 0;
    bit          m_cap;
    bit          m_pop;
    entry_t      m_e;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: a queue of entries the FIFO should hold, plus counters.
    always @(posedge Clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            m_cnt  = 0;
            m_ts   = '0;
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            m_pop = (m_cnt > 0) && bus.trace_ready;
            m_cap = trace_en && bus.RegWrite && !(SKIP_ZERO && bus.WriteRegister == 5'd0);
            if (m_cap && (m_cnt < DEPTH || m_pop)) begin
                m_e.pc = bus.PC;
                m_e.r  = bus.WriteRegister;
                m_e.d  = bus.WriteDataReg;
                m_e.ts = m_ts;
                exp_q.push_back(m_e);
                m_cnt++;
                if (ovf_clr) begin
                    m_ovf  = 1'b0;
                    m_drop = 0;
                end
            end else if (m_cap) begin
                m_ovf  = 1'b1;
                m_drop = ovf_clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
            end else if (ovf_clr) begin
                m_ovf  = 1'b0;
                m_drop = 0;
            end
            if (m_pop) m_cnt--;
            m_ts = m_ts + 16'd1;
        end
    end

    // Monitor: compares DUT state and head entry against the model every cycle.
    always @(negedge Clk) begin
        if (reset) begin
            check("fifo_count", fifo_count, m_cnt);
            check("overflow", overflow, m_ovf);
            check("drop_count", drop_count, m_drop);
            check("trace_valid", bus.trace_valid, exp_q.size() != 0);
            if (bus.trace_valid && exp_q.size() != 0) begin
                check("trace_pc", bus.trace_pc, exp_q[0].pc);
                check("trace_reg", bus.trace_reg, exp_q[0].r);
                check("trace_data", bus.trace_data, exp_q[0].d);
                check("trace_ts", bus.trace_ts, exp_q[0].ts);
            end
            if (exp_q.size() != 0 && bus.trace_ready) void'(exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wb(input logic rw, input logic [4:0] r, input logic [31:0] d, input logic [31:0] pc);
        bus.RegWrite      = rw;
        bus.WriteRegister = r;
        bus.WriteDataReg  = d;
        bus.PC            = pc;
    endtask

    initial begin
        int guard;
        bus.trace_ready = 1'b0;
        wb(1'b0, 5'd0, 32'd0, 32'd0);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        reset = 1'b1;
        #1;
        check("rst_valid", bus.trace_valid, 1'b0);
        check("rst_pc", bus.trace_pc, 32'd0);
        check("rst_reg", bus.trace_reg, 5'd0);
        check("rst_data", bus.trace_data, 32'd0);
        check("rst_ts", bus.trace_ts, 16'd0);
        check("rst_count", fifo_count, 4'd0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_drop", drop_count, 8'd0);
        tick();

        // single writeback, held for several cycles, then popped
        trace_en = 1'b1;
        wb(1'b1, 5'd8, 32'hDEADBEEF, 32'h40);
        tick();
        wb(1'b0, 5'd0, 32'd0, 32'd0);
        check("t1_valid", bus.trace_valid, 1'b1);
        check("t1_data", bus.trace_data, 32'hDEADBEEF);
        check("t1_count", fifo_count, 4'd1);
        repeat (5) tick();
        bus.trace_ready = 1'b1;
        tick();
        bus.trace_ready = 1'b0;
        check("t1_empty", bus.trace_valid, 1'b0);

        // register 0 and disabled capture are both ignored
        wb(1'b1, 5'd0, 32'h11, 32'h44);
        tick();
        trace_en = 1'b0;
        wb(1'b1, 5'd5, 32'h22, 32'h48);
        tick();
        trace_en = 1'b1;
        wb(1'b0, 5'd0, 32'd0, 32'd0);
        tick();
        check("t2_count", fifo_count, 4'd0);
        check("t2_ovf", overflow, 1'b0);

        // overfill by two
        for (int i = 1; i <= 10; i++) begin
            wb(1'b1, 5'd3, 32'(i), 32'h100 + 32'(4 * i));
            tick();
        end
        wb(1'b0, 5'd0, 32'd0, 32'd0);
        tick();
        check("t3_count", fifo_count, 4'd8);
        check("t3_ovf", overflow, 1'b1);
        check("t3_drop", drop_count, 8'd2);

        // capture while full with a simultaneous pop is accepted
        wb(1'b1, 5'd9, 32'hAA, 32'h200);
        bus.trace_ready = 1'b1;
        tick();
        wb(1'b0, 5'd0, 32'd0, 32'd0);
        bus.trace_ready = 1'b0;
        check("t4_count", fifo_count, 4'd8);
        check("t4_drop", drop_count, 8'd2);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t4_ovf_clr", overflow, 1'b0);
        check("t4_drop_clr", drop_count, 8'd0);
        bus.trace_ready = 1'b1;
        repeat (9) tick();

        // streaming through with an always-ready sink
        for (int i = 0; i < 20; i++) begin
            wb(1'b1, 5'(1 + i % 31), $urandom, 32'h1000 + 32'(4 * i));
            tick();
        end
        wb(1'b0, 5'd0, 32'd0, 32'd0);
        tick();

        // random traffic with a slow sink
        for (int i = 0; i < 400; i++) begin
            trace_en        = ($urandom % 8) != 0;
            bus.trace_ready = ($urandom % 3) == 0;
            ovf_clr         = ($urandom % 40) == 0;
            wb(($urandom % 4) != 0, (($urandom % 4) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom);
            tick();
        end
        trace_en = 1'b1;
        ovf_clr = 1'b0;
        bus.trace_ready = 1'b1;
        wb(1'b0, 5'd0, 32'd0, 32'd0);
        repeat (12) tick();

        // timestamp wrap
        guard = 0;
        while (m_ts != 16'hFFF8 && guard < 70000) begin
            tick();
            guard++;
        end
        check("ts_wrap_reached", guard < 70000, 1'b1);
        for (int i = 0; i < 16; i++) begin
            wb(1'b1, 5'd4, 32'h5000 + 32'(i), 32'h3000 + 32'(4 * i));
            tick();
        end
        wb(1'b0, 5'd0, 32'd0, 32'd0);
        tick();

        // asynchronous reset with entries held
        bus.trace_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wb(1'b1, 5'd6, 32'h6000 + 32'(i), 32'h4000);
            tick();
        end
        wb(1'b0, 5'd0, 32'd0, 32'd0);
        tick();
        check("t8_count", fifo_count, 4'd5);
        @(negedge Clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_valid", bus.trace_valid, 1'b0);
        check("async_count", fifo_count, 4'd0);
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        reset = 1'b1;
        wb(1'b1, 5'd7, 32'h1234, 32'h80);
        tick();
        wb(1'b0, 5'd0, 32'd0, 32'd0);
        check("post_rst_valid", bus.trace_valid, 1'b1);
        check("post_rst_ts", bus.trace_ts, 16'd0);
        check("post_rst_data", bus.trace_data, 32'h1234);
        bus.trace_ready = 1'b1;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
